// File: rtl/unet_pool_pkg.sv
// Shared types and helpers for the UNET 2-D pooling engine.
package unet_pool_pkg;

  typedef enum logic {
    POOL_MAX = 1'b0,
    POOL_AVG = 1'b1
  } pool_mode_e;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StRead,
    StDrain,
    StWrite,
    StFin
  } pool_state_e;

  // Accumulator width: room for the sum of up to (2^K_W)^2 samples.
  function automatic int unsigned acc_w(input int unsigned data_w, input int unsigned k_w);
    return data_w + 2 * k_w;
  endfunction

endpackage

// File: rtl/unet_pool_reduce.sv
// Window reducer: running max or running sum, with the average taken as a right shift.
module unet_pool_reduce
  import unet_pool_pkg::*;
#(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned K_W    = 3,
  parameter bit          SIGNED = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sample,
  input  logic              first,
  input  logic              valid,
  input  pool_mode_e        mode,
  input  logic [2:0]        shift,
  output logic [DATA_W-1:0] result
);

  localparam int unsigned ACC_W = acc_w(DATA_W, K_W);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] ext;
  logic [ACC_W-1:0] avg;
  logic             gt;

  always_comb begin
    ext = {{(ACC_W - DATA_W){SIGNED & sample[DATA_W-1]}}, sample};
    if (SIGNED) begin
      gt  = $signed(ext) > $signed(acc_q);
      avg = $signed(acc_q) >>> shift;
    end else begin
      gt  = ext > acc_q;
      avg = acc_q >> shift;
    end
    result = (mode == POOL_AVG) ? avg[DATA_W-1:0] : acc_q[DATA_W-1:0];
  end

  // Strict compare so ties keep the earlier sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else if (valid) begin
      if (first) begin
        acc_q <= ext;
      end else if (mode == POOL_AVG) begin
        acc_q <= acc_q + ext;
      end else if (gt) begin
        acc_q <= ext;
      end
    end
  end

endmodule

// File: rtl/unet_pool2d_engine.sv
// Channel-major PxP / stride-S max or average pooling from an input RAM into an output RAM.
module unet_pool2d_engine
  import unet_pool_pkg::*;
#(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DIM_W  = 7,
  parameter int unsigned K_W    = 3,
  parameter bit          SIGNED = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [DIM_W-1:0]  channels,
  input  logic [DIM_W-1:0]  height,
  input  logic [DIM_W-1:0]  width,
  input  logic [K_W-1:0]    pool_size,
  input  logic [K_W-1:0]    stride,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] input_rsc_radr,
  output logic              input_rsc_re,
  input  logic [DATA_W-1:0] input_rsc_q,
  output logic              input_rsc_clken,
  output logic              input_triosy_lz,
  output logic [ADDR_W-1:0] output_rsc_wadr,
  output logic [DATA_W-1:0] output_rsc_d,
  output logic              output_rsc_we,
  output logic              output_rsc_clken,
  output logic              output_triosy_lz
);

  pool_state_e      state_q;
  pool_mode_e       mode_q;
  logic [DIM_W-1:0] c_q, h_q, w_q, oh_q, ow_q, ch_q, oy_q, ox_q;
  logic [K_W-1:0]   p_q, s_q, ky_q, kx_q;
  logic [ADDR_W-1:0] hw_q, ohow_q, radr_q, wadr_q;
  logic busy_q, done_q, error_q, re_q, we_q, rd_pend_q, rd_first_q;

  logic             cfg_bad, kx_last, k_last, ox_last, oy_last, ch_last;
  logic [DIM_W-1:0] p_ext, oh_calc, ow_calc, ox_nx, oy_nx, ch_nx;
  logic [K_W-1:0]   s_div, kx_nx, ky_nx;
  logic [2:0]       avg_shift;

  function automatic logic [ADDR_W-1:0] rd_addr(
    input logic [DIM_W-1:0]  c, oy, ox,
    input logic [K_W-1:0]    ky, kx, s,
    input logic [DIM_W-1:0]  w,
    input logic [ADDR_W-1:0] hw
  );
    logic [ADDR_W-1:0] row, col;
    row = ADDR_W'(oy) * ADDR_W'(s) + ADDR_W'(ky);
    col = ADDR_W'(ox) * ADDR_W'(s) + ADDR_W'(kx);
    return ADDR_W'(c) * hw + row * ADDR_W'(w) + col;
  endfunction

  always_comb begin
    p_ext   = DIM_W'(p_q);
    s_div   = (s_q == '0) ? K_W'(1) : s_q;
    cfg_bad = (p_q == '0) || (s_q == '0) || (c_q == '0) || (p_ext > h_q) || (p_ext > w_q) ||
              ((mode_q == POOL_AVG) &&
               !((p_q == K_W'(1)) || (p_q == K_W'(2)) || (p_q == K_W'(4))));
    oh_calc = (h_q - p_ext) / DIM_W'(s_div) + DIM_W'(1);
    ow_calc = (w_q - p_ext) / DIM_W'(s_div) + DIM_W'(1);

    kx_last = (kx_q == p_q - K_W'(1));
    k_last  = kx_last && (ky_q == p_q - K_W'(1));
    kx_nx   = kx_last ? '0 : kx_q + K_W'(1);
    ky_nx   = kx_last ? ky_q + K_W'(1) : ky_q;

    ox_last = (ox_q == ow_q - DIM_W'(1));
    oy_last = (oy_q == oh_q - DIM_W'(1));
    ch_last = (ch_q == c_q - DIM_W'(1));
    ox_nx   = ox_last ? '0 : ox_q + DIM_W'(1);
    oy_nx   = !ox_last ? oy_q : (oy_last ? '0 : oy_q + DIM_W'(1));
    ch_nx   = (ox_last && oy_last) ? ch_q + DIM_W'(1) : ch_q;

    avg_shift = (p_q == K_W'(4)) ? 3'd4 : ((p_q == K_W'(2)) ? 3'd2 : 3'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      mode_q     <= POOL_MAX;
      c_q        <= '0;
      h_q        <= '0;
      w_q        <= '0;
      oh_q       <= '0;
      ow_q       <= '0;
      ch_q       <= '0;
      oy_q       <= '0;
      ox_q       <= '0;
      p_q        <= '0;
      s_q        <= '0;
      ky_q       <= '0;
      kx_q       <= '0;
      hw_q       <= '0;
      ohow_q     <= '0;
      radr_q     <= '0;
      wadr_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      re_q       <= 1'b0;
      we_q       <= 1'b0;
      rd_pend_q  <= 1'b0;
      rd_first_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      we_q       <= 1'b0;
      // RAM data returns one cycle after the read, so the reducer follows re by one cycle.
      rd_pend_q  <= re_q;
      rd_first_q <= re_q && (ky_q == '0) && (kx_q == '0);
      case (state_q)
        StIdle: begin
          if (start) begin
            mode_q  <= pool_mode_e'(mode);
            c_q     <= channels;
            h_q     <= height;
            w_q     <= width;
            p_q     <= pool_size;
            s_q     <= stride;
            busy_q  <= 1'b1;
            state_q <= StCheck;
          end
        end
        StCheck: begin
          if (cfg_bad) begin
            error_q <= 1'b1;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StFin;
          end else begin
            oh_q    <= oh_calc;
            ow_q    <= ow_calc;
            hw_q    <= ADDR_W'(h_q) * ADDR_W'(w_q);
            ohow_q  <= ADDR_W'(oh_calc) * ADDR_W'(ow_calc);
            ch_q    <= '0;
            oy_q    <= '0;
            ox_q    <= '0;
            ky_q    <= '0;
            kx_q    <= '0;
            re_q    <= 1'b1;
            radr_q  <= '0;
            state_q <= StRead;
          end
        end
        StRead: begin
          if (k_last) begin
            re_q    <= 1'b0;
            state_q <= StDrain;
          end else begin
            ky_q   <= ky_nx;
            kx_q   <= kx_nx;
            radr_q <= rd_addr(ch_q, oy_q, ox_q, ky_nx, kx_nx, s_q, w_q, hw_q);
          end
        end
        StDrain: begin
          we_q    <= 1'b1;
          wadr_q  <= ADDR_W'(ch_q) * ohow_q + ADDR_W'(oy_q) * ADDR_W'(ow_q) + ADDR_W'(ox_q);
          state_q <= StWrite;
        end
        StWrite: begin
          if (ox_last && oy_last && ch_last) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StFin;
          end else begin
            ch_q    <= ch_nx;
            oy_q    <= oy_nx;
            ox_q    <= ox_nx;
            ky_q    <= '0;
            kx_q    <= '0;
            re_q    <= 1'b1;
            radr_q  <= rd_addr(ch_nx, oy_nx, ox_nx, '0, '0, s_q, w_q, hw_q);
            state_q <= StRead;
          end
        end
        StFin: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  unet_pool_reduce #(
    .DATA_W(DATA_W),
    .K_W   (K_W),
    .SIGNED(SIGNED)
  ) u_reduce (
    .clk   (clk),
    .rst   (rst),
    .sample(input_rsc_q),
    .first (rd_first_q),
    .valid (rd_pend_q),
    .mode  (mode_q),
    .shift (avg_shift),
    .result(output_rsc_d)
  );

  assign busy             = busy_q;
  assign done             = done_q;
  assign error            = error_q;
  assign input_rsc_radr   = radr_q;
  assign input_rsc_re     = re_q;
  assign input_rsc_clken  = 1'b1;
  assign input_triosy_lz  = done_q;
  assign output_rsc_wadr  = wadr_q;
  assign output_rsc_we    = we_q;
  assign output_rsc_clken = 1'b1;
  assign output_triosy_lz = done_q;

endmodule

// File: tb/tb_unet_pool2d_engine.sv
// Bench: unsigned and signed engines run the same jobs against a plain-arithmetic pooling model.
module tb_unet_pool2d_engine;

  localparam int OUT_SZ = 1024;

  typedef struct {
    bit          mode;
    int          c, h, w, p, s;
    int          fill;   // 0: value = address, 1: random, 2: pat
    logic [47:0] pat;
  } job_t;

  logic        clk = 1'b0;
  logic        rst, start, mode;
  logic [6:0]  channels, height, width;
  logic [2:0]  pool_size, stride;

  logic        busy_u, done_u, error_u, re_u, iclk_u, itz_u, we_u, oclk_u, otz_u;
  logic [14:0] radr_u, wadr_u;
  logic [11:0] q_u, d_u;
  logic        busy_s, done_s, error_s, re_s, iclk_s, itz_s, we_s, oclk_s, otz_s;
  logic [14:0] radr_s, wadr_s;
  logic [11:0] q_s, d_s;

  logic [11:0] in_mem [0:32767];
  logic [11:0] out_u [0:OUT_SZ-1];
  logic [11:0] out_s [0:OUT_SZ-1];
  bit          wr_u  [0:OUT_SZ-1];
  bit          wr_s  [0:OUT_SZ-1];
  logic [11:0] exp_u [0:OUT_SZ-1];
  logic [11:0] exp_s [0:OUT_SZ-1];
  int          nwr_u, nwr_s, clash;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (re_u) q_u <= in_mem[radr_u];
    if (re_s) q_s <= in_mem[radr_s];
  end

  unet_pool2d_engine #(.SIGNED(1'b0)) u_dut_u (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .channels(channels), .height(height), .width(width),
    .pool_size(pool_size), .stride(stride),
    .busy(busy_u), .done(done_u), .error(error_u),
    .input_rsc_radr(radr_u), .input_rsc_re(re_u), .input_rsc_q(q_u),
    .input_rsc_clken(iclk_u), .input_triosy_lz(itz_u),
    .output_rsc_wadr(wadr_u), .output_rsc_d(d_u), .output_rsc_we(we_u),
    .output_rsc_clken(oclk_u), .output_triosy_lz(otz_u)
  );

  unet_pool2d_engine #(.SIGNED(1'b1)) u_dut_s (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .channels(channels), .height(height), .width(width),
    .pool_size(pool_size), .stride(stride),
    .busy(busy_s), .done(done_s), .error(error_s),
    .input_rsc_radr(radr_s), .input_rsc_re(re_s), .input_rsc_q(q_s),
    .input_rsc_clken(iclk_s), .input_triosy_lz(itz_s),
    .output_rsc_wadr(wadr_s), .output_rsc_d(d_s), .output_rsc_we(we_s),
    .output_rsc_clken(oclk_s), .output_triosy_lz(otz_s)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, want);
    end
  endtask

  function automatic job_t mk_job(input bit m, input int c, input int h, input int w,
                                  input int p, input int s, input int fill,
                                  input logic [47:0] pat);
    job_t j;
    j.mode = m; j.c = c; j.h = h; j.w = w; j.p = p; j.s = s; j.fill = fill; j.pat = pat;
    return j;
  endfunction

  function automatic int elem(input logic [11:0] x, input bit sg);
    int v;
    if (sg) v = int'($signed(x));
    else    v = int'({20'd0, x});
    return v;
  endfunction

  task automatic fill_mem(input job_t j);
    for (int a = 0; a < j.c * j.h * j.w; a++) begin
      case (j.fill)
        0:       in_mem[a] = 12'(a);
        1:       in_mem[a] = 12'($urandom);
        default: in_mem[a] = (a < 4) ? j.pat[a*12 +: 12] : 12'd0;
      endcase
    end
  endtask

  // Reference: pooled value of every output pixel from the map held in in_mem.
  task automatic model(input job_t j, input bit sg, output int n, output bit bad);
    int oh, ow, v, best, sum, area, res, idx;
    bad = (j.p == 0) || (j.s == 0) || (j.c == 0) || (j.p > j.h) || (j.p > j.w) ||
          (j.mode && !(j.p inside {1, 2, 4}));
    n = 0;
    if (!bad) begin
      oh = (j.h - j.p) / j.s + 1;
      ow = (j.w - j.p) / j.s + 1;
      area = j.p * j.p;
      for (int c = 0; c < j.c; c++)
        for (int oy = 0; oy < oh; oy++)
          for (int ox = 0; ox < ow; ox++) begin
            best = 0;
            sum  = 0;
            for (int ky = 0; ky < j.p; ky++)
              for (int kx = 0; kx < j.p; kx++) begin
                v = elem(in_mem[c*j.h*j.w + (oy*j.s + ky)*j.w + ox*j.s + kx], sg);
                sum += v;
                if ((ky == 0 && kx == 0) || v > best) best = v;
              end
            if (j.mode) begin
              res = sum / area;
              if ((sum % area != 0) && sum < 0) res--;
            end else begin
              res = best;
            end
            idx = c*oh*ow + oy*ow + ox;
            if (sg) exp_s[idx] = res[11:0];
            else    exp_u[idx] = res[11:0];
            n++;
          end
    end
  endtask

  // Starts in the cycle after the previous call returned (i.e. right after a done).
  task automatic run_job(input job_t j, input int glitch_at, output int lat, output bit err_seen);
    bit got;
    @(negedge clk);
    for (int a = 0; a < OUT_SZ; a++) begin
      wr_u[a] = 1'b0;
      wr_s[a] = 1'b0;
    end
    nwr_u = 0; nwr_s = 0; clash = 0;
    fill_mem(j);
    mode = j.mode; channels = 7'(j.c); height = 7'(j.h); width = 7'(j.w);
    pool_size = 3'(j.p); stride = 3'(j.s);
    start = 1'b1;
    lat = 0; got = 1'b0; err_seen = 1'b0;
    for (int cyc = 1; cyc <= 8000 && !got; cyc++) begin
      @(negedge clk);
      start = (cyc == glitch_at);
      if (cyc == glitch_at) begin
        mode = ~mode;
        channels = channels + 7'd1;
      end
      if (cyc == 1) check("busy_after_start", {31'd0, busy_u}, 32'd1);
      if (we_u) begin
        nwr_u++;
        if (wadr_u < 15'(OUT_SZ)) begin out_u[wadr_u] = d_u; wr_u[wadr_u] = 1'b1; end
      end
      if (we_s) begin
        nwr_s++;
        if (wadr_s < 15'(OUT_SZ)) begin out_s[wadr_s] = d_s; wr_s[wadr_s] = 1'b1; end
      end
      if ((re_u && we_u) || (re_s && we_s)) clash++;
      if (done_u) begin
        got = 1'b1;
        lat = cyc;
        err_seen = error_u;
        check("done_signed_same_cycle", {31'd0, done_s}, 32'd1);
        check("error_signed_agrees", {31'd0, error_s}, {31'd0, error_u});
        check("busy_low_at_done", {30'd0, busy_u, busy_s}, 32'd0);
        check("triosy_with_done", {28'd0, itz_u, otz_u, itz_s, otz_s}, 32'hF);
      end
    end
    start = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL done_timeout got no done expected done within 8000 cycles");
    end
  endtask

  task automatic verify(input job_t j, input int lat, input bit err_seen);
    int  n_u, n_s;
    bit  bad_u, bad_s;
    model(j, 1'b0, n_u, bad_u);
    model(j, 1'b1, n_s, bad_s);
    check("latency", lat, bad_u ? 2 : 2 + n_u * (j.p * j.p + 2));
    check("error_flag", {31'd0, err_seen}, {31'd0, bad_u});
    check("write_count_u", nwr_u, n_u);
    check("write_count_s", nwr_s, n_s);
    check("re_we_overlap", clash, 0);
    for (int i = 0; i < n_u; i++)
      check("pixel_u", wr_u[i] ? {20'd0, out_u[i]} : 32'hFFFF_FFFF, {20'd0, exp_u[i]});
    for (int i = 0; i < n_s; i++)
      check("pixel_s", wr_s[i] ? {20'd0, out_s[i]} : 32'hFFFF_FFFF, {20'd0, exp_s[i]});
  endtask

  job_t jobs [7];
  int   max4 [4];

  initial begin
    int   lat, cnt;
    bit   err_seen;
    job_t j;

    jobs[0] = mk_job(1'b0, 1, 4, 4, 2, 2, 0, 48'd0);
    jobs[1] = mk_job(1'b1, 1, 2, 2, 2, 2, 2, {12'd0, 12'd1, 12'hFFE, 12'hFFD});
    jobs[2] = mk_job(1'b1, 1, 2, 2, 2, 2, 2, {12'd1, 12'd1, 12'hFFE, 12'hFFD});
    jobs[3] = mk_job(1'b0, 2, 5, 5, 3, 2, 0, 48'd0);
    jobs[4] = mk_job(1'b1, 1, 4, 4, 3, 1, 1, 48'd0);
    jobs[5] = mk_job(1'b0, 1, 4, 4, 5, 1, 1, 48'd0);
    jobs[6] = mk_job(1'b0, 1, 4, 4, 2, 0, 1, 48'd0);
    max4[0] = 5; max4[1] = 7; max4[2] = 13; max4[3] = 15;

    rst = 1'b1; start = 1'b0; mode = 1'b0;
    channels = '0; height = '0; width = '0; pool_size = '0; stride = '0;
    repeat (3) @(negedge clk);
    check("reset_ctrl", {25'd0, busy_u, done_u, error_u, re_u, we_u, itz_u, otz_u}, 32'd0);
    check("reset_addr_data", {radr_u, 5'd0, d_u}, 32'd0);
    check("reset_clken", {30'd0, iclk_u, oclk_u}, 32'd3);
    rst = 1'b0;

    // Table jobs run back to back: each start lands in the cycle after the previous done.
    for (int i = 0; i < 7; i++) begin
      run_job(jobs[i], 0, lat, err_seen);
      verify(jobs[i], lat, err_seen);
      if (i == 0)
        for (int k = 0; k < 4; k++) check("max_4x4_out", {20'd0, out_u[k]}, max4[k]);
      if (i == 1 || i == 2) check("avg_signed_floor", {20'd0, out_s[0]}, 32'hFFF);
      if (i == 3) begin
        check("overlap_out0", {20'd0, out_u[0]}, 32'd12);
        check("overlap_out7", {20'd0, out_u[7]}, 32'd49);
      end
    end

    // start pulsed mid-job must not disturb the job or cause a second done.
    run_job(jobs[3], 20, lat, err_seen);
    verify(jobs[3], lat, err_seen);
    cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (done_u || done_s || we_u || we_s) cnt++;
    end
    check("no_second_done", cnt, 0);

    // Reset in the middle of READ aborts the job.
    @(negedge clk);
    fill_mem(jobs[0]);
    mode = 1'b0; channels = 7'd1; height = 7'd4; width = 7'd4; pool_size = 3'd2; stride = 3'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("re_high_in_read", {31'd0, re_u}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_ctrl_u", {25'd0, busy_u, done_u, error_u, re_u, we_u, itz_u, otz_u}, 32'd0);
    check("abort_ctrl_s", {25'd0, busy_s, done_s, error_s, re_s, we_s, itz_s, otz_s}, 32'd0);
    check("abort_addr_u", {radr_u, 2'd0, wadr_u}, 32'd0);
    check("abort_data", {d_u, 8'd0, d_s}, 32'd0);
    check("abort_clken", {28'd0, iclk_u, oclk_u, iclk_s, oclk_s}, 32'hF);
    rst = 1'b0;
    cnt = 0;
    repeat (60) begin
      @(negedge clk);
      if (done_u || done_s || we_u || we_s || busy_u) cnt++;
    end
    check("quiet_after_abort", cnt, 0);

    // Randomized back-to-back jobs.
    for (int r = 0; r < 6; r++) begin
      j.mode = 1'($urandom_range(0, 1));
      if (j.mode) begin
        case ($urandom_range(0, 2))
          0:       j.p = 1;
          1:       j.p = 2;
          default: j.p = 4;
        endcase
      end else begin
        j.p = int'($urandom_range(1, 4));
      end
      j.h = int'($urandom_range(j.p, 8));
      j.w = int'($urandom_range(j.p, 8));
      j.s = int'($urandom_range(1, 3));
      j.c = int'($urandom_range(1, 3));
      j.fill = 1;
      j.pat = 48'd0;
      run_job(j, 0, lat, err_seen);
      verify(j, lat, err_seen);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
